// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard / stall controller.
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hazard_state_t;

   localparam int unsigned REG_ZERO = 0;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;
   logic         w_full;

   assign w_full = &r_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (inc && !w_full) begin
         r_q <= r_q + W'(1);
      end
   end

   assign q = r_q;

endmodule : sat_counter

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector with configurable penalty, memory-busy freeze,
// branch-flush arbitration and saturating stall statistics.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W           = 5,
   parameter int unsigned LOAD_USE_CYCLES = 1,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   input  logic             rs_used_id,
   input  logic             rt_used_id,
   input  logic [REG_W-1:0] rd_exe,
   input  logic             load_exe,
   input  logic             mem_busy,
   input  logic             branch_taken_id,
   input  logic             stat_clr,
   output logic             pc_stall,
   output logic             if_stall,
   output logic             id_bubble,
   output logic             if_flush,
   output logic             pipe_freeze,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] freeze_cycles
);

   if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 4) begin : g_bad_load_use_cycles
      $error("hazard_stall_ctrl: LOAD_USE_CYCLES must be in 1..4");
   end

   localparam int unsigned REM_W =
      (LOAD_USE_CYCLES > 1) ? $clog2(LOAD_USE_CYCLES) : 1;
   // The hit cycle itself is the first bubble, so LU_STALL covers L-1 more.
   localparam logic [REM_W-1:0] REM_INIT =
      (LOAD_USE_CYCLES > 1) ? REM_W'(LOAD_USE_CYCLES - 2) : '0;
   localparam logic MULTI_CYCLE = (LOAD_USE_CYCLES > 1);

   hazard_state_t    r_state;
   logic [REM_W-1:0] r_rem;

   logic w_rd_nonzero;
   logic w_rs_match;
   logic w_rt_match;
   logic w_hit;

   assign w_rd_nonzero = (rd_exe != REG_W'(REG_ZERO));
   assign w_rs_match   = rs_used_id && (rd_exe == rs_id);
   assign w_rt_match   = rt_used_id && (rd_exe == rt_id);
   assign w_hit        = load_exe && w_rd_nonzero && (w_rs_match || w_rt_match);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RUN;
         r_rem   <= '0;
      end else if (!mem_busy) begin
         unique case (r_state)
            RUN: begin
               if (w_hit && MULTI_CYCLE) begin
                  r_state <= LU_STALL;
                  r_rem   <= REM_INIT;
               end
            end
            LU_STALL: begin
               if (r_rem == '0) begin
                  r_state <= RUN;
               end else begin
                  r_rem <= r_rem - REM_W'(1);
               end
            end
            default: begin
               r_state <= RUN;
               r_rem   <= '0;
            end
         endcase
      end
   end

   // Freeze outranks everything; a branch held by a stall flushes only once it ends.
   always_comb begin
      pc_stall    = 1'b0;
      if_stall    = 1'b0;
      id_bubble   = 1'b0;
      if_flush    = 1'b0;
      pipe_freeze = 1'b0;
      if (!reset_n) begin
         pc_stall = 1'b0;
      end else if (mem_busy) begin
         pipe_freeze = 1'b1;
         pc_stall    = 1'b1;
         if_stall    = 1'b1;
      end else if (r_state == LU_STALL || w_hit) begin
         pc_stall  = 1'b1;
         if_stall  = 1'b1;
         id_bubble = 1'b1;
      end else begin
         if_flush = branch_taken_id;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stat_clr),
      .inc     (id_bubble),
      .q       (stall_cycles)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_freeze_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stat_clr),
      .inc     (pipe_freeze),
      .q       (freeze_cycles)
   );

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Randomised and directed bench for hazard_stall_ctrl: one L=3 instance and
// one L=1 instance with narrow counters share stimulus against a count-down model.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] rs_id, rt_id, rd_exe;
   logic       rs_used_id, rt_used_id, load_exe, mem_busy, branch_taken_id, stat_clr;

   logic        a_pc, a_if, a_bub, a_flush, a_frz;
   logic [15:0] a_stall, a_freeze;
   logic        b_pc, b_if, b_bub, b_flush, b_frz;
   logic [3:0]  b_stall, b_freeze;

   int n_checks = 0;
   int n_errors = 0;

   // Model state per instance: index 0 = L3/CNT16, index 1 = L1/CNT4.
   int lu   [2] = '{3, 1};
   int cmax [2] = '{65535, 15};
   int left [2];
   int scnt [2];
   int fcnt [2];
   logic e_pc [2], e_bub [2], e_flush [2], e_frz [2];

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_W(5), .LOAD_USE_CYCLES(3), .CNT_W(16)) u_dut_a (
      .clk             (clk),
      .reset_n         (reset_n),
      .rs_id           (rs_id),
      .rt_id           (rt_id),
      .rs_used_id      (rs_used_id),
      .rt_used_id      (rt_used_id),
      .rd_exe          (rd_exe),
      .load_exe        (load_exe),
      .mem_busy        (mem_busy),
      .branch_taken_id (branch_taken_id),
      .stat_clr        (stat_clr),
      .pc_stall        (a_pc),
      .if_stall        (a_if),
      .id_bubble       (a_bub),
      .if_flush        (a_flush),
      .pipe_freeze     (a_frz),
      .stall_cycles    (a_stall),
      .freeze_cycles   (a_freeze)
   );

   hazard_stall_ctrl #(.REG_W(5), .LOAD_USE_CYCLES(1), .CNT_W(4)) u_dut_b (
      .clk             (clk),
      .reset_n         (reset_n),
      .rs_id           (rs_id),
      .rt_id           (rt_id),
      .rs_used_id      (rs_used_id),
      .rt_used_id      (rt_used_id),
      .rd_exe          (rd_exe),
      .load_exe        (load_exe),
      .mem_busy        (mem_busy),
      .branch_taken_id (branch_taken_id),
      .stat_clr        (stat_clr),
      .pc_stall        (b_pc),
      .if_stall        (b_if),
      .id_bubble       (b_bub),
      .if_flush        (b_flush),
      .pipe_freeze     (b_frz),
      .stall_cycles    (b_stall),
      .freeze_cycles   (b_freeze)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic ref_hit();
      if (!load_exe || rd_exe == 5'd0) return 1'b0;
      return (rs_used_id && rd_exe == rs_id) || (rt_used_id && rd_exe == rt_id);
   endfunction

   task automatic model_expect();
      logic h;
      h = ref_hit();
      for (int k = 0; k < 2; k++) begin
         e_pc[k] = 0; e_bub[k] = 0; e_flush[k] = 0; e_frz[k] = 0;
         if (mem_busy) begin
            e_frz[k] = 1; e_pc[k] = 1;
         end else if (left[k] > 0 || h) begin
            e_pc[k] = 1; e_bub[k] = 1;
         end else begin
            e_flush[k] = branch_taken_id;
         end
      end
   endtask

   task automatic model_advance();
      logic h;
      h = ref_hit();
      for (int k = 0; k < 2; k++) begin
         if (!mem_busy) begin
            if (left[k] > 0) left[k]--;
            else if (h) left[k] = lu[k] - 1;
         end
         if (stat_clr) begin
            scnt[k] = 0; fcnt[k] = 0;
         end else begin
            if (e_bub[k] && scnt[k] < cmax[k]) scnt[k]++;
            if (e_frz[k] && fcnt[k] < cmax[k]) fcnt[k]++;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_expect();
      check_val("a_pc_stall",  32'(a_pc),     32'(e_pc[0]));
      check_val("a_if_stall",  32'(a_if),     32'(e_pc[0]));
      check_val("a_id_bubble", 32'(a_bub),    32'(e_bub[0]));
      check_val("a_if_flush",  32'(a_flush),  32'(e_flush[0]));
      check_val("a_freeze",    32'(a_frz),    32'(e_frz[0]));
      check_val("a_stall_cnt", 32'(a_stall),  32'(scnt[0]));
      check_val("a_frz_cnt",   32'(a_freeze), 32'(fcnt[0]));
      check_val("b_pc_stall",  32'(b_pc),     32'(e_pc[1]));
      check_val("b_if_stall",  32'(b_if),     32'(e_pc[1]));
      check_val("b_id_bubble", 32'(b_bub),    32'(e_bub[1]));
      check_val("b_if_flush",  32'(b_flush),  32'(e_flush[1]));
      check_val("b_freeze",    32'(b_frz),    32'(e_frz[1]));
      check_val("b_stall_cnt", 32'(b_stall),  32'(scnt[1]));
      check_val("b_frz_cnt",   32'(b_freeze), 32'(fcnt[1]));
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_a_outs"}, 32'({a_pc, a_if, a_bub, a_flush, a_frz}), 32'd0);
      check_val({tag, "_b_outs"}, 32'({b_pc, b_if, b_bub, b_flush, b_frz}), 32'd0);
   endtask

   // Hazard stimulus drives inputs that would stall if reset were not forcing zero.
   task automatic pulse_reset();
      reset_n = 1'b0;
      #2;
      check_outputs_zero("mid_reset");
      check_val("reset_a_stall_cnt", 32'(a_stall), 32'd0);
      for (int k = 0; k < 2; k++) begin
         left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end
      #1;
      reset_n = 1'b1;
   endtask

   task automatic set_hit(input logic on);
      load_exe = on; rd_exe = 5'd8; rs_id = 5'd8; rs_used_id = 1'b1;
      rt_id = 5'd2; rt_used_id = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      rs_id = '0; rt_id = '0; rd_exe = '0;
      rs_used_id = 0; rt_used_id = 0; load_exe = 0;
      mem_busy = 0; branch_taken_id = 0; stat_clr = 0;
      for (int k = 0; k < 2; k++) begin
         left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end
      set_hit(1'b1);
      mem_busy = 1'b1;
      #8;
      check_outputs_zero("in_reset");
      check_val("reset_b_stall_cnt", 32'(b_stall), 32'd0);
      set_hit(1'b0);
      mem_busy = 1'b0;
      #4;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single hit: one bubble on L=1, three on L=3.
      set_hit(1'b1);
      cycle();
      set_hit(1'b0);
      repeat (4) cycle();

      // Register-0 and unused-operand matches never stall.
      load_exe = 1; rd_exe = 5'd0; rs_id = 5'd0; rs_used_id = 1;
      cycle();
      rd_exe = 5'd5; rs_id = 5'd1; rt_id = 5'd5; rt_used_id = 0;
      cycle();
      load_exe = 0;
      cycle();

      // Freeze for two cycles during the second bubble.
      set_hit(1'b1);
      cycle();
      set_hit(1'b0);
      mem_busy = 1;
      repeat (2) cycle();
      mem_busy = 0;
      repeat (3) cycle();

      // Branch alongside a hit: flush waits for the stall to end.
      branch_taken_id = 1;
      set_hit(1'b1);
      cycle();
      set_hit(1'b0);
      repeat (3) cycle();
      branch_taken_id = 0;
      cycle();

      // Reset mid-stall.
      set_hit(1'b1);
      cycle();
      set_hit(1'b0);
      cycle();
      pulse_reset();
      repeat (2) cycle();

      // Saturate the 4-bit counter, then clear.
      set_hit(1'b1);
      repeat (20) cycle();
      set_hit(1'b0);
      repeat (3) cycle();
      check_val("b_stall_saturated", 32'(b_stall), 32'd15);
      stat_clr = 1;
      cycle();
      stat_clr = 0;
      repeat (2) cycle();

      // Random traffic over a small register range so hits are frequent.
      for (int i = 0; i < 3000; i++) begin
         rs_id           = 5'($urandom_range(0, 3));
         rt_id           = 5'($urandom_range(0, 3));
         rd_exe          = 5'($urandom_range(0, 3));
         rs_used_id      = 1'($urandom_range(0, 1));
         rt_used_id      = 1'($urandom_range(0, 1));
         load_exe        = ($urandom_range(0, 99) < 40);
         mem_busy        = ($urandom_range(0, 99) < 15);
         branch_taken_id = ($urandom_range(0, 99) < 20);
         stat_clr        = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 299) == 0) pulse_reset();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_hazard_stall_ctrl
